// File: rtl/mc_div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_div_ctrl_pkg
//  Description : Shared definitions for the multi-cycle divide sequencer:
//                data width, divide-class opcodes, FSM state encoding and
//                small opcode decode helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package mc_div_ctrl_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [1:0] MC_OP_DIV  = 2'd0;
    localparam logic [1:0] MC_OP_DIVU = 2'd1;
    localparam logic [1:0] MC_OP_REM  = 2'd2;
    localparam logic [1:0] MC_OP_REMU = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // DIV and REM treat operands as two's-complement.
    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == MC_OP_DIV) || (op == MC_OP_REM);
    endfunction

    // REM and REMU return the remainder; DIV and DIVU return the quotient.
    function automatic logic is_rem_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_div_ctrl_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : mc_div_ctrl_div_step
//  Description : One combinational radix-2 restoring division step.
//  Ports       : i_part     partial remainder {rem, next dividend bit}, WIDTH+1
//                i_divisor  divisor magnitude, WIDTH
//                o_rem      next remainder, WIDTH
//                o_qbit     quotient bit produced by this step
//  Revision    : 1.0  initial release
// ============================================================================
module mc_div_ctrl_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_part,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    // The partial remainder carries one extra bit because the previous
    // remainder can be as large as divisor-1, i.e. nearly 2^WIDTH.
    assign o_qbit = (i_part >= {1'b0, i_divisor});

    // When the subtraction happens the true difference is below the divisor,
    // so a WIDTH-bit modular subtract gives the exact result.
    assign o_rem  = o_qbit ? (i_part[WIDTH-1:0] - i_divisor) : i_part[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/mc_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mc_div_ctrl
//  Description : Sequencer for the multi-cycle DIV/DIVU/REM/REMU resource.
//                Latches operand magnitudes on start, iterates one quotient
//                bit per cycle, and presents the sign-corrected result for one
//                cycle in DONE. Divide-by-zero and signed overflow bypass the
//                iteration. Optional macro MC_DIV_EARLY_OUT_EN also bypasses
//                when |dividend| < |divisor|.
//  Ports       : clk, rst_n        clock, asynchronous active-low reset
//                start_i           divide-class op present in EX
//                op_i              MC_OP_DIV/DIVU/REM/REMU
//                rs1_i, rs2_i      dividend, divisor
//                busy_o            freeze request to the core (combinational)
//                done_o            result valid this cycle
//                result_o          quotient or remainder (registered)
//  Revision    : 1.0  initial release
// ============================================================================
module mc_div_ctrl
    import mc_div_ctrl_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_ones    = {WIDTH{1'b1}};

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_dividend;   // shifts left; quotient bits fill from LSB
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_q, r_neg_r;

    // ---------------- operand decode in IDLE ----------------
    logic             w_signed, w_sign1, w_sign2;
    logic [WIDTH-1:0] w_mag1, w_mag2;
    logic             w_div0, w_ovf, w_early, w_bypass;
    logic [WIDTH-1:0] w_byp_q, w_byp_r, w_byp_res;

    assign w_signed = is_signed_op(op_i);
    assign w_sign1  = w_signed & rs1_i[WIDTH-1];
    assign w_sign2  = w_signed & rs2_i[WIDTH-1];
    assign w_mag1   = w_sign1 ? (~rs1_i + c_one) : rs1_i;
    assign w_mag2   = w_sign2 ? (~rs2_i + c_one) : rs2_i;
    assign w_div0   = (rs2_i == '0);
    assign w_ovf    = w_signed && (rs1_i == c_min_neg) && (rs2_i == c_ones);

`ifdef MC_DIV_EARLY_OUT_EN
    assign w_early  = !w_div0 && (w_mag1 < w_mag2);
`else
    assign w_early  = 1'b0;
`endif

    assign w_bypass = w_div0 | w_ovf | w_early;

    // Bypass results use the raw dividend, so no sign correction is needed.
    always_comb begin
        w_byp_q = '0;
        w_byp_r = rs1_i;
        if (w_div0) begin
            w_byp_q = c_ones;
            w_byp_r = rs1_i;
        end else if (w_ovf) begin
            w_byp_q = c_min_neg;
            w_byp_r = '0;
        end
    end
    assign w_byp_res = is_rem_op(op_i) ? w_byp_r : w_byp_q;

    // ---------------- iteration datapath ----------------
    logic [WIDTH-1:0] w_step_rem, w_quot_fin, w_q_fix, w_r_fix, w_run_res;
    logic             w_step_q;

    mc_div_ctrl_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_part   ({r_rem, r_dividend[WIDTH-1]}),
        .i_divisor(r_divisor),
        .o_rem    (w_step_rem),
        .o_qbit   (w_step_q)
    );

    // Values as they will stand after the final iteration.
    assign w_quot_fin = {r_dividend[WIDTH-2:0], w_step_q};
    assign w_q_fix    = r_neg_q ? (~w_quot_fin + c_one) : w_quot_fin;
    assign w_r_fix    = r_neg_r ? (~w_step_rem + c_one) : w_step_rem;
    assign w_run_res  = is_rem_op(r_op) ? w_r_fix : w_q_fix;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start_i) w_state_nxt = w_bypass ? ST_DONE : ST_RUN;
            ST_RUN:  if (r_cnt == '0) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;   // start_i still shows the finished op
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_result   <= '0;
            r_cnt      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_op       <= op_i;
                        r_dividend <= w_mag1;
                        r_divisor  <= w_mag2;
                        r_rem      <= '0;
                        r_neg_q    <= w_sign1 ^ w_sign2;
                        r_neg_r    <= w_sign1;
                        r_cnt      <= CNT_W'(WIDTH - 1);
                        if (w_bypass) r_result <= w_byp_res;
                    end
                end
                ST_RUN: begin
                    r_rem      <= w_step_rem;
                    r_dividend <= w_quot_fin;
                    r_cnt      <= r_cnt - 1'b1;
                    if (r_cnt == '0) r_result <= w_run_res;
                end
                default: ;
            endcase
        end
    end

    // Gated by rst_n so the freeze drops the moment reset asserts, even with
    // start_i still high.
    assign busy_o   = rst_n & (((r_state == ST_IDLE) & start_i) | (r_state == ST_RUN));
    assign done_o   = (r_state == ST_DONE);
    assign result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mc_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_div_ctrl
//  Description : Self-checking bench for mc_div_ctrl. A driver issues divide
//                ops the way the frozen core would (start held until DONE),
//                pushing the expected result and stall length into a queue; a
//                monitor pops and compares on every done_o.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mc_div_ctrl;
    import mc_div_ctrl_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_i = 1'b0;
    logic [1:0]   op_i = 2'd0;
    logic [W-1:0] rs1_i = '0;
    logic [W-1:0] rs2_i = '0;
    logic         busy_o, done_o;
    logic [W-1:0] result_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] res;
        int           busy;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   busy_cnt = 0;

    mc_div_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .op_i    (op_i),
        .rs1_i   (rs1_i),
        .rs2_i   (rs2_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .result_o(result_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Reference: architectural RISC-V M-extension division semantics.
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  output logic [W-1:0] res, output int busy);
        logic [W-1:0] q, r;
        bit           byp, early, sgn;
        longint       sa, sbv, aa, ab;
`ifdef MC_DIV_EARLY_OUT_EN
        early = 1'b1;
`else
        early = 1'b0;
`endif
        sgn = (op == MC_OP_DIV) || (op == MC_OP_REM);
        if (b == 0) begin
            q = '1; r = a; byp = 1'b1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = '0; byp = 1'b1;
        end else if (sgn) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
            q   = W'(sa / sbv);
            r   = W'(sa % sbv);
            aa  = (sa < 0) ? -sa : sa;
            ab  = (sbv < 0) ? -sbv : sbv;
            byp = early && (aa < ab);
        end else begin
            q = a / b; r = a % b;
            byp = early && (a < b);
        end
        res  = op[1] ? r : q;
        busy = byp ? 1 : W + 1;
    endfunction

    // Monitor: sampled on negedge, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
            end else begin
                if (busy_o) busy_cnt++;
                if (done_o) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done actual=1 required=0 result=%h", result_o);
                    end else begin
                        e = sb.pop_front();
                        check_val({e.name, "_result"}, result_o, e.res);
                        check_int({e.name, "_busy_cycles"}, busy_cnt, e.busy);
                        check_val({e.name, "_busy_in_done"}, {31'd0, busy_o}, '0);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    // Caller is at posedge+2 of a cycle in which the DUT is IDLE.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input string nm, input int gap);
        exp_t e;
        bit   seen = 1'b0;
        start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
        model(op, a, b, e.res, e.busy);
        e.name = nm;
        sb.push_back(e);
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (done_o) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done", nm);
            sb.delete();
        end
        // start_i stays high through DONE, as the frozen instruction would.
        @(posedge clk); #2;
        if (gap > 0) begin
            start_i = 1'b0;
            repeat (gap) @(posedge clk);
            #2;
        end
    endtask

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'd1;
            2:       return '1;
            3:       return 32'h8000_0000;
            4:       return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check_val("reset_busy",   {31'd0, busy_o}, '0);
        check_val("reset_done",   {31'd0, done_o}, '0);
        check_val("reset_result", result_o, '0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        run_op(MC_OP_DIVU, 32'd100, 32'd7, "divu_100_7", 1);
        run_op(MC_OP_REMU, 32'd100, 32'd7, "remu_100_7", 1);
        run_op(MC_OP_DIV,  -32'sd7, 32'd2, "div_m7_2", 0);
        run_op(MC_OP_REM,  -32'sd7, 32'd2, "rem_m7_2", 0);
        run_op(MC_OP_REM,  32'd7, -32'sd2, "rem_7_m2", 1);
        run_op(MC_OP_DIV,  32'd5, 32'd0, "div_5_0", 0);
        run_op(MC_OP_REM,  32'd5, 32'd0, "rem_5_0", 1);
        run_op(MC_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 0);
        run_op(MC_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 0);
        run_op(MC_OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, "divu_big", 0);
        run_op(MC_OP_DIVU, 32'd9, 32'd3, "divu_9_3_b2b", 0);
        run_op(MC_OP_DIVU, 32'd3, 32'd10, "divu_3_10", 2);

        // Reset in the middle of an iteration.
        start_i = 1'b1; op_i = MC_OP_DIVU; rs1_i = 32'd1000; rs2_i = 32'd3;
        repeat (11) @(posedge clk);
        #3;
        check_val("busy_in_run", {31'd0, busy_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("midreset_busy",   {31'd0, busy_o}, '0);
        check_val("midreset_done",   {31'd0, done_o}, '0);
        check_val("midreset_result", result_o, '0);
        start_i = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        run_op(MC_OP_DIV, 32'd1000, -32'sd3, "after_reset", 1);

        for (int i = 0; i < 200; i++) begin
            run_op(2'($urandom_range(0, 3)), pick_val(), pick_val(),
                   "random", $urandom_range(0, 2));
        end

        repeat (3) @(posedge clk);
        #2;
        check_int("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
